// File: rtl/mode_select_ctrl_if.sv
// ============================================================================
// Module   : mode_select_ctrl_if
// Purpose  : Commit handshake between the front-panel mode selector and the
//            top-level mode FSM that consumes the committed mode.
// Signals  : next_state - committed mode index, stable while load is high
//            load       - commit request, held until acknowledged
//            load_ack   - consumer accepts next_state
// Modports : master (selector side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mode_select_ctrl_if #(
  parameter int MODE_W = 3
) ();

  logic [MODE_W-1:0] next_state;
  logic              load;
  logic              load_ack;

  modport master (
    output next_state,
    output load,
    input  load_ack
  );

  modport slave (
    input  next_state,
    input  load,
    output load_ack
  );

endinterface

`default_nettype wire

// File: rtl/mode_select_ctrl.sv
// ============================================================================
// Module   : mode_select_ctrl
// Purpose  : Front-panel mode selector. Synchronises and debounces three raw
//            push-buttons, adds hold-to-auto-repeat on prev/next, reverts the
//            browse cursor after an inactivity timeout and delivers the
//            committed mode through a load/load_ack handshake.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            i_btn_prev     - raw button, steps cursor +1 (wrapping)
//            i_btn_next     - raw button, steps cursor -1 (wrapping)
//            i_btn_confirm  - raw button, commits the cursor
//            bus (master)   - next_state / load / load_ack handshake
//            o_cursor       - mode currently highlighted
//            o_uncommitted  - high when cursor differs from next_state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_select_ctrl #(
  parameter int NUM_MODES    = 5,
  parameter int MODE_W       = 3,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_PER   = 100,
  parameter int TIMEOUT      = 5000
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_btn_prev,
  input  wire logic              i_btn_next,
  input  wire logic              i_btn_confirm,
  mode_select_ctrl_if.master     bus,
  output logic [MODE_W-1:0]      o_cursor,
  output logic                   o_uncommitted
);

  // Button index: 0 = prev, 1 = next, 2 = confirm
  localparam int                NB        = 3;
  localparam int                DB_W      = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0]   c_DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [MODE_W-1:0] c_LAST    = MODE_W'(NUM_MODES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  logic [NB-1:0]     w_raw;
  logic [NB-1:0]     r_sync1;
  logic [NB-1:0]     r_sync2;
  logic [NB-1:0]     r_db;
  logic [NB-1:0]     r_db_q;
  logic [DB_W-1:0]   r_dbcnt [NB];
  logic [NB-1:0]     w_press;
  logic [1:0]        w_rep;

  logic              w_ev_prev;
  logic              w_ev_next;
  logic              w_confirm;
  logic              w_any_ev;
  logic              w_step_up;
  logic              w_step_dn;
  logic              w_timeout;
  logic [MODE_W-1:0] w_cur_inc;
  logic [MODE_W-1:0] w_cur_dec;

  state_t            r_state;
  logic [MODE_W-1:0] r_cursor;
  logic [MODE_W-1:0] r_next_state;
  logic              r_load;
  logic              r_uncommitted;

  assign w_raw = {i_btn_confirm, i_btn_next, i_btn_prev};

  // --------------------------------------------------------------------------
  // Synchroniser + debounce. The debounced level only flips after the
  // synchronised input has disagreed with it for DEBOUNCE_CYC cycles in a row.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < NB; i++) begin
        r_dbcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dbcnt[i] == c_DB_LAST) begin
            r_db[i]    <= ~r_db[i];
            r_dbcnt[i] <= '0;
          end else begin
            r_dbcnt[i] <= r_dbcnt[i] + DB_W'(1);
          end
        end else begin
          r_dbcnt[i] <= '0;
        end
      end
    end
  end

  // Single-cycle pulse on the debounced rising edge only
  assign w_press = r_db & ~r_db_q;

  // --------------------------------------------------------------------------
  // Auto-repeat for prev/next. A down-counter is loaded on the press event so
  // that it hits zero REPEAT_DLY cycles later, then reloads for every
  // REPEAT_PER cycles while the debounced level stays high.
  // --------------------------------------------------------------------------
  generate
    if (REPEAT_DLY > 0) begin : g_repeat
      localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int RP_W   = (RP_MAX < 2) ? 1 : $clog2(RP_MAX);
      localparam logic [RP_W-1:0] c_DLY_LD = RP_W'(REPEAT_DLY - 1);
      localparam logic [RP_W-1:0] c_PER_LD = RP_W'(REPEAT_PER - 1);

      logic [RP_W-1:0] r_rcnt [2];
      logic [1:0]      r_rarm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rarm <= '0;
          for (int i = 0; i < 2; i++) begin
            r_rcnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (w_press[i]) begin
              r_rcnt[i] <= c_DLY_LD;
              r_rarm[i] <= 1'b1;
            end else if (!r_db[i]) begin
              r_rcnt[i] <= '0;
              r_rarm[i] <= 1'b0;
            end else if (r_rarm[i]) begin
              if (r_rcnt[i] == '0) begin
                r_rcnt[i] <= c_PER_LD;
              end else begin
                r_rcnt[i] <= r_rcnt[i] - RP_W'(1);
              end
            end
          end
        end
      end

      always_comb begin
        w_rep = '0;
        for (int i = 0; i < 2; i++) begin
          w_rep[i] = r_db[i] & r_rarm[i] & (r_rcnt[i] == '0);
        end
      end
    end else begin : g_no_repeat
      assign w_rep = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Event decode and cursor arithmetic (explicit wrap, no natural overflow)
  // --------------------------------------------------------------------------
  assign w_ev_prev = w_press[0] | w_rep[0];
  assign w_ev_next = w_press[1] | w_rep[1];
  assign w_confirm = w_press[2];
  assign w_any_ev  = w_ev_prev | w_ev_next | w_confirm;
  // Opposing steps in the same cycle cancel out
  assign w_step_up = w_ev_prev & ~w_ev_next;
  assign w_step_dn = w_ev_next & ~w_ev_prev;

  assign w_cur_inc = (r_cursor == c_LAST) ? '0 : (r_cursor + MODE_W'(1));
  assign w_cur_dec = (r_cursor == '0) ? c_LAST : (r_cursor - MODE_W'(1));

  // --------------------------------------------------------------------------
  // Inactivity timeout. Counts only while the cursor differs from the
  // committed mode, saturates at TIMEOUT and forces a revert while saturated.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int              TO_W = $clog2(TIMEOUT + 1);
      localparam logic [TO_W-1:0] c_TO = TO_W'(TIMEOUT);

      logic [TO_W-1:0] r_idle;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_idle <= '0;
        end else if (w_any_ev || !r_uncommitted) begin
          r_idle <= '0;
        end else if (r_idle != c_TO) begin
          r_idle <= r_idle + TO_W'(1);
        end
      end

      assign w_timeout = (r_idle == c_TO);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Cursor and blink flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor      <= '0;
      r_uncommitted <= 1'b0;
    end else begin
      if (w_step_up) begin
        r_cursor <= w_cur_inc;
      end else if (w_step_dn) begin
        r_cursor <= w_cur_dec;
      end else if (w_timeout) begin
        r_cursor <= r_next_state;
      end
      r_uncommitted <= (r_cursor != r_next_state);
    end
  end

  // --------------------------------------------------------------------------
  // Commit handshake. next_state captures the register value of the cursor,
  // i.e. the pre-step value when a step lands in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_next_state <= '0;
      r_load       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_confirm) begin
            r_next_state <= r_cursor;
            r_load       <= 1'b1;
            r_state      <= S_PEND;
          end
        end
        S_PEND: begin
          if (bus.load_ack) begin
            r_load  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_load  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.next_state = r_next_state;
  assign bus.load       = r_load;
  assign o_cursor       = r_cursor;
  assign o_uncommitted  = r_uncommitted;

endmodule

`default_nettype wire
